// File: rtl/cmd_pkg.sv
// Command codes and classifier labels shared between the KWS bridge and the command FSM,
// plus the label/confidence to command mapping.
package cmd_pkg;

  typedef enum logic [2:0] {
    WELCOME   = 3'd0,
    RECORDING = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5,
    STOP      = 3'd6,
    SILENCE   = 3'd7
  } cmd_t;

  localparam logic [3:0] LBL_SILENCE = 4'd0;
  localparam logic [3:0] LBL_UP      = 4'd1;
  localparam logic [3:0] LBL_DOWN    = 4'd2;
  localparam logic [3:0] LBL_LEFT    = 4'd3;
  localparam logic [3:0] LBL_RIGHT   = 4'd4;
  localparam logic [3:0] LBL_STOP    = 4'd5;

  // Confidence equal to conf_min is accepted; unknown labels fold to SILENCE.
  function automatic cmd_t label2cmd(input logic [3:0] label,
                                     input logic [7:0] conf,
                                     input logic [7:0] conf_min);
    cmd_t c;
    c = SILENCE;
    if (conf >= conf_min) begin
      case (label)
        LBL_UP:    c = UP;
        LBL_DOWN:  c = DOWN;
        LBL_LEFT:  c = LEFT;
        LBL_RIGHT: c = RIGHT;
        LBL_STOP:  c = STOP;
        default:   c = SILENCE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/kws_cmd_bridge_rise_detect.sv
// Rising-edge detector: registers the input and pulses for one cycle on a 0->1 change.
module rise_detect (
  input  logic clk,
  input  logic rstb,
  input  logic d_i,
  output logic pulse_o
);

  logic sample_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sample_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sample_q <= d_i;
      armed_q  <= 1'b1;
    end
  end

  // A level already high when reset releases must fall and rise again to count.
  assign pulse_o = d_i && !sample_q && armed_q;

endmodule

// File: rtl/kws_cmd_bridge.sv
// Bridges the command FSM recording flag and the ARM classifier result onto the
// 3-bit command bus: timed recording window, result wait with timeout, command hold.
module kws_cmd_bridge
  import cmd_pkg::*;
#(
  parameter int unsigned REC_CYCLES     = 50_000_000,
  parameter int unsigned RESULT_TIMEOUT = 100_000_000,
  parameter int unsigned HOLD_CYCLES    = 25_000_000,
  parameter logic [7:0]  CONF_MIN       = 8'd128,
  parameter int unsigned CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rec_req,
  input  logic       res_valid,
  input  logic [3:0] res_label,
  input  logic [7:0] res_conf,
  output logic       res_ready,
  output cmd_t       cmd,
  output logic       rec_active,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, REC, WAIT_RES, HOLD} state_t;

  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(REC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(RESULT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic             tout_q, tout_d;
  logic             start;
  logic             hs;

  rise_detect u_start (
    .clk     (clk),
    .rstb    (rstb),
    .d_i     (rec_req),
    .pulse_o (start)
  );

  assign res_ready = (state_q == WAIT_RES);
  assign hs        = res_valid && res_ready;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= WELCOME;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_d = WELCOME;
        cnt_d = '0;
        if (start) begin
          state_d = REC;
          cmd_d   = RECORDING;
        end
      end
      REC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == REC_LAST) begin
          state_d = WAIT_RES;
          cnt_d   = '0;
        end
      end
      WAIT_RES: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the last timeout cycle still wins.
        if (hs) begin
          state_d = HOLD;
          cnt_d   = '0;
          cmd_d   = label2cmd(res_label, res_conf, CONF_MIN);
        end else if (cnt_q == TOUT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          cmd_d   = SILENCE;
          tout_d  = 1'b1;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          cmd_d   = WELCOME;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        cmd_d   = WELCOME;
      end
    endcase
  end

  assign cmd         = cmd_q;
  assign rec_active  = (state_q == REC);
  assign timeout_err = tout_q;

endmodule
